csr_trap_unit: RTL

//  Machine-mode CSR file and trap sequencer. It receives the decoder's CSR request
//  (ren/wen/state/raddr/waddr), services csrrw/csrrs, ecall, mret and CLINT timer

---
 rtl/csr_trap_unit_if.sv | 31 +++
 rtl/csr_trap_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit_if.sv
// Request/response bundle between decode/execute and the machine-mode CSR/trap unit.
// The master side is the decoder/IFU; the slave side is csr_trap_unit.
interface csr_trap_unit_if #(
    parameter int XLEN = 64
);
    logic            i_CSR_valid;
    logic            i_CSR_ren;
    logic            i_CSR_wen;
    logic [1:0]      i_CSR_state;
    logic [11:0]     i_CSR_raddr;
    logic [11:0]     i_CSR_waddr;
    logic [XLEN-1:0] i_CSR_wdata;
    logic [XLEN-1:0] i_CSR_pc;
    logic            i_CSR_mtip;
    logic [XLEN-1:0] o_CSR_rdata;
    logic            o_CSR_redirect;
    logic [XLEN-1:0] o_CSR_target;
    logic            o_CSR_busy;

    modport master (
        output i_CSR_valid, i_CSR_ren, i_CSR_wen, i_CSR_state, i_CSR_raddr,
               i_CSR_waddr, i_CSR_wdata, i_CSR_pc, i_CSR_mtip,
        input  o_CSR_rdata, o_CSR_redirect, o_CSR_target, o_CSR_busy
    );

    modport slave (
        input  i_CSR_valid, i_CSR_ren, i_CSR_wen, i_CSR_state, i_CSR_raddr,
               i_CSR_waddr, i_CSR_wdata, i_CSR_pc, i_CSR_mtip,
        output o_CSR_rdata, o_CSR_redirect, o_CSR_target, o_CSR_busy
    );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer: csrrw/csrrs, ecall, mret and CLINT
// timer interrupts, with a registered one-cycle PC redirect toward fetch.
module csr_trap_unit #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MSTATUS_RST = 64'h0000_000a_0000_1800,
    parameter logic [XLEN-1:0] ECALL_CAUSE = 64'd11
) (
    input  logic           i_CSR_clk,
    input  logic           i_CSR_rst_n,
    csr_trap_unit_if.slave csr
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hb00;

    localparam logic [1:0] REQ_IDLE  = 2'b00;
    localparam logic [1:0] REQ_RW    = 2'b01;
    localparam logic [1:0] REQ_ECALL = 2'b10;
    localparam logic [1:0] REQ_MRET  = 2'b11;

    localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, {(XLEN-4){1'b0}}, 3'b111};
    localparam logic [XLEN-1:0] ZERO      = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONE       = {{(XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [XLEN-1:0] mstatus_r, mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r, mip_r, mcycle_r;
    logic [XLEN-1:0] mstatus_nxt_s, mie_nxt_s, mtvec_nxt_s, mscratch_nxt_s;
    logic [XLEN-1:0] mepc_nxt_s, mcause_nxt_s, mip_nxt_s, mcycle_nxt_s;
    logic [XLEN-1:0] target_r, target_nxt_s;
    logic            accept_s, rw_s, ecall_s, mret_s, irq_s;
    logic            wr_en_s;
    logic [XLEN-1:0] wr_old_s, wr_val_s;
    logic            redirect_s, busy_s;

    function automatic logic [XLEN-1:0] csr_sel(
        input logic [11:0]     addr,
        input logic [XLEN-1:0] v_mstatus, v_mie, v_mtvec, v_mscratch,
        input logic [XLEN-1:0] v_mepc, v_mcause, v_mip, v_mcycle
    );
        case (addr)
            A_MSTATUS:  csr_sel = v_mstatus;
            A_MIE:      csr_sel = v_mie;
            A_MTVEC:    csr_sel = v_mtvec;
            A_MSCRATCH: csr_sel = v_mscratch;
            A_MEPC:     csr_sel = v_mepc;
            A_MCAUSE:   csr_sel = v_mcause;
            A_MIP:      csr_sel = v_mip;
            A_MCYCLE:   csr_sel = v_mcycle;
            default:    csr_sel = {XLEN{1'b0}};
        endcase
    endfunction

    // Request decode; a pending timer interrupt only fires on an otherwise idle retire slot.
    always_comb begin
        accept_s = csr.i_CSR_valid && (state_r == ST_IDLE);
        rw_s     = accept_s && (csr.i_CSR_state == REQ_RW);
        ecall_s  = accept_s && (csr.i_CSR_state == REQ_ECALL);
        mret_s   = accept_s && (csr.i_CSR_state == REQ_MRET);
        irq_s    = accept_s && (csr.i_CSR_state == REQ_IDLE) && mstatus_r[3]
                   && mie_r[7] && csr.i_CSR_mtip;
        wr_old_s = csr_sel(csr.i_CSR_waddr, mstatus_r, mie_r, mtvec_r, mscratch_r,
                           mepc_r, mcause_r, mip_r, mcycle_r);
        if (rw_s && csr.i_CSR_wen) begin
            wr_en_s  = 1'b1;
            wr_val_s = csr.i_CSR_wdata;
        end else if (rw_s && csr.i_CSR_ren && (csr.i_CSR_wdata != ZERO)) begin
            wr_en_s  = 1'b1;
            wr_val_s = wr_old_s | csr.i_CSR_wdata;
        end else begin
            wr_en_s  = 1'b0;
            wr_val_s = wr_old_s;
        end
    end

    // Read port always shows the pre-write value.
    always_comb begin
        csr.o_CSR_rdata = csr_sel(csr.i_CSR_raddr, mstatus_r, mie_r, mtvec_r, mscratch_r,
                                  mepc_r, mcause_r, mip_r, mcycle_r);
    end

    // CSR next-state: software writes, then ecall/mret/irq side effects.
    always_comb begin
        mstatus_nxt_s  = mstatus_r;
        mie_nxt_s      = mie_r;
        mtvec_nxt_s    = mtvec_r;
        mscratch_nxt_s = mscratch_r;
        mepc_nxt_s     = mepc_r;
        mcause_nxt_s   = mcause_r;
        mcycle_nxt_s   = mcycle_r + ONE;
        mip_nxt_s      = ZERO;
        mip_nxt_s[7]   = csr.i_CSR_mtip;
        target_nxt_s   = target_r;
        if (wr_en_s) begin
            case (csr.i_CSR_waddr)
                A_MSTATUS:  mstatus_nxt_s  = wr_val_s;
                A_MIE:      mie_nxt_s      = wr_val_s;
                A_MTVEC:    mtvec_nxt_s    = wr_val_s;
                A_MSCRATCH: mscratch_nxt_s = wr_val_s;
                A_MEPC:     mepc_nxt_s     = wr_val_s;
                A_MCAUSE:   mcause_nxt_s   = wr_val_s;
                A_MCYCLE:   mcycle_nxt_s   = wr_val_s;
                default:    mcycle_nxt_s   = mcycle_r + ONE;
            endcase
        end else if (ecall_s || irq_s) begin
            mepc_nxt_s           = csr.i_CSR_pc;
            mcause_nxt_s         = ecall_s ? ECALL_CAUSE : IRQ_CAUSE;
            mstatus_nxt_s[7]     = mstatus_r[3];
            mstatus_nxt_s[3]     = 1'b0;
            mstatus_nxt_s[12:11] = ecall_s ? 2'b11 : mstatus_r[12:11];
            target_nxt_s         = {mtvec_r[XLEN-1:2], 2'b00};
        end else if (mret_s) begin
            mstatus_nxt_s[3]     = mstatus_r[7];
            mstatus_nxt_s[7]     = 1'b1;
            mstatus_nxt_s[12:11] = 2'b11;
            target_nxt_s         = mepc_r;
        end else begin
            target_nxt_s = target_r;
        end
    end

    // CSR and redirect-target storage.
    always_ff @(posedge i_CSR_clk or negedge i_CSR_rst_n) begin
        if (!i_CSR_rst_n) begin
            mstatus_r  <= MSTATUS_RST;
            mie_r      <= ZERO;
            mtvec_r    <= ZERO;
            mscratch_r <= ZERO;
            mepc_r     <= ZERO;
            mcause_r   <= ZERO;
            mip_r      <= ZERO;
            mcycle_r   <= ZERO;
            target_r   <= ZERO;
        end else begin
            mstatus_r  <= mstatus_nxt_s;
            mie_r      <= mie_nxt_s;
            mtvec_r    <= mtvec_nxt_s;
            mscratch_r <= mscratch_nxt_s;
            mepc_r     <= mepc_nxt_s;
            mcause_r   <= mcause_nxt_s;
            mip_r      <= mip_nxt_s;
            mcycle_r   <= mcycle_nxt_s;
            target_r   <= target_nxt_s;
        end
    end

    // FSM state register.
    always_ff @(posedge i_CSR_clk or negedge i_CSR_rst_n) begin
        if (!i_CSR_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: TRAP lasts exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ecall_s || mret_s || irq_s) begin
                    state_nxt_s = ST_TRAP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TRAP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded straight from the state flop so they drop on async reset.
    always_comb begin
        redirect_s = 1'b0;
        busy_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                redirect_s = 1'b0;
                busy_s     = 1'b0;
            end
            ST_TRAP: begin
                redirect_s = 1'b1;
                busy_s     = 1'b1;
            end
            default: begin
                redirect_s = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

    assign csr.o_CSR_redirect = redirect_s;
    assign csr.o_CSR_busy     = busy_s;
    assign csr.o_CSR_target   = target_r;

endmodule
